// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the two-master data-memory arbiter.
// The state encoding is fixed because debug tooling reads it.
package dmem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } state_t;

  localparam logic [31:0] PERIPH_BASE_DEF = 32'h4000_0000;
  localparam logic [7:0]  LED_OFF         = 8'h0C;
  localparam logic [7:0]  DIGI_OFF        = 8'h10;

  typedef struct packed {
    logic        we;
    logic        byte_rd;
    logic [31:0] addr;
    logic [31:0] wdata;
  } dmem_req_t;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the data memory.
// The master modport is the requester/memory side, the slave modport is the arbiter.
interface dmem_arbiter_if;
  logic        m0_req, m0_we, m0_byte;
  logic [31:0] m0_addr, m0_wdata;
  logic        m1_req, m1_we, m1_byte;
  logic [31:0] m1_addr, m1_wdata;
  logic        m0_gnt, m1_gnt;
  logic        m0_rvalid, m1_rvalid;
  logic [31:0] rdata;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_read, mem_byteread, mem_write, mem_exwr;
  logic [31:0] mem_rdata;
  logic        bus_err;

  modport slave (
    input  m0_req, m0_we, m0_byte, m0_addr, m0_wdata,
    input  m1_req, m1_we, m1_byte, m1_addr, m1_wdata,
    input  mem_rdata,
    output m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, rdata,
    output mem_addr, mem_wdata, mem_read, mem_byteread, mem_write, mem_exwr,
    output bus_err
  );

  modport master (
    output m0_req, m0_we, m0_byte, m0_addr, m0_wdata,
    output m1_req, m1_we, m1_byte, m1_addr, m1_wdata,
    output mem_rdata,
    input  m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, rdata,
    input  mem_addr, mem_wdata, mem_read, mem_byteread, mem_write, mem_exwr,
    input  bus_err
  );
endinterface

// File: rtl/dmem_addr_decode.sv
// Peripheral window decode: a 256-byte window at PERIPH_BASE, in which only the
// LED and DIGI offsets accept writes.
module dmem_addr_decode
  import dmem_arbiter_pkg::*;
#(
  parameter logic [31:0] PERIPH_BASE = PERIPH_BASE_DEF
) (
  input  logic [31:0] i_addr,
  output logic        o_in_win,
  output logic        o_is_ex
);
  assign o_in_win = (i_addr[31:8] == PERIPH_BASE[31:8]);
  assign o_is_ex  = o_in_win && ((i_addr[7:0] == LED_OFF) || (i_addr[7:0] == DIGI_OFF));
endmodule

// File: rtl/dmem_arbiter.sv
// Two-master data-memory arbiter with bounded hold fairness, peripheral window
// routing and a registered shared read-data path.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned HOLD_MAX    = 4,
  parameter logic [31:0] PERIPH_BASE = PERIPH_BASE_DEF
) (
  input  logic           clk,
  input  logic           reset,
  dmem_arbiter_if.slave  bus
);
  localparam int unsigned CW = (HOLD_MAX < 1) ? 1 : $clog2(HOLD_MAX + 1);

  state_t        r_state;
  logic [CW-1:0] r_hold_cnt;
  logic [31:0]   r_rdata;
  logic          r_rvalid0, r_rvalid1, r_bus_err;

  logic          w_gnt0, w_gnt1, w_any, w_hold_exp;
  logic          w_other_req, w_same_owner;
  logic          w_in_win, w_is_ex, w_bad;
  dmem_req_t     w_m0, w_m1, w_sel;

  assign w_m0 = '{we: bus.m0_we, byte_rd: bus.m0_byte, addr: bus.m0_addr, wdata: bus.m0_wdata};
  assign w_m1 = '{we: bus.m1_we, byte_rd: bus.m1_byte, addr: bus.m1_addr, wdata: bus.m1_wdata};

  assign w_hold_exp = (r_hold_cnt >= CW'(HOLD_MAX));

  // Grants are gated by reset so no access leaks out while the block is held.
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (!reset) begin
      if (bus.m0_req && bus.m1_req) begin
        unique case (r_state)
          ST_OWN0: if (w_hold_exp) w_gnt1 = 1'b1; else w_gnt0 = 1'b1;
          ST_OWN1: if (w_hold_exp) w_gnt0 = 1'b1; else w_gnt1 = 1'b1;
          default: w_gnt0 = 1'b1;
        endcase
      end else begin
        w_gnt0 = bus.m0_req;
        w_gnt1 = bus.m1_req;
      end
    end
  end

  assign w_any        = w_gnt0 | w_gnt1;
  assign w_sel        = w_gnt1 ? w_m1 : w_m0;
  assign w_other_req  = w_gnt0 ? bus.m1_req : bus.m0_req;
  assign w_same_owner = (w_gnt0 && (r_state == ST_OWN0)) || (w_gnt1 && (r_state == ST_OWN1));

  dmem_addr_decode #(.PERIPH_BASE(PERIPH_BASE)) u_dec (
    .i_addr   (w_sel.addr),
    .o_in_win (w_in_win),
    .o_is_ex  (w_is_ex)
  );

  // Any window access except a write to LED/DIGI is an error, reads included.
  assign w_bad = w_any && w_in_win && !(w_sel.we && w_is_ex);

  assign bus.m0_gnt       = w_gnt0;
  assign bus.m1_gnt       = w_gnt1;
  assign bus.mem_addr     = w_sel.addr;
  assign bus.mem_wdata    = w_sel.wdata;
  assign bus.mem_write    = w_any &  w_sel.we & ~w_in_win;
  assign bus.mem_exwr     = w_any &  w_sel.we &  w_is_ex;
  assign bus.mem_read     = w_any & ~w_sel.we & ~w_in_win & ~w_sel.byte_rd;
  assign bus.mem_byteread = w_any & ~w_sel.we & ~w_in_win &  w_sel.byte_rd;
  assign bus.m0_rvalid    = r_rvalid0;
  assign bus.m1_rvalid    = r_rvalid1;
  assign bus.rdata        = r_rdata;
  assign bus.bus_err      = r_bus_err;

  // hold_cnt counts contended grants in the current run, including the grant
  // that started it, so each master gets exactly HOLD_MAX grants per turn.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_hold_cnt <= '0;
      r_rdata    <= '0;
      r_rvalid0  <= 1'b0;
      r_rvalid1  <= 1'b0;
      r_bus_err  <= 1'b0;
    end else begin
      r_rvalid0 <= w_gnt0 & ~w_sel.we;
      r_rvalid1 <= w_gnt1 & ~w_sel.we;
      if (w_any && !w_sel.we)
        r_rdata <= w_in_win ? '0 : bus.mem_rdata;
      if (w_bad)
        r_bus_err <= 1'b1;
      if (!w_any) begin
        r_state    <= ST_IDLE;
        r_hold_cnt <= '0;
      end else begin
        r_state <= w_gnt1 ? ST_OWN1 : ST_OWN0;
        if (!w_other_req)
          r_hold_cnt <= '0;
        else if (w_same_owner)
          r_hold_cnt <= r_hold_cnt + 1'b1;
        else
          r_hold_cnt <= CW'(1);
      end
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a behavioural model.
module tb_dmem_arbiter;
  localparam int HM = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  dmem_arbiter_if bus();

  dmem_arbiter #(.HOLD_MAX(HM), .PERIPH_BASE(32'h4000_0000)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit in_win(input logic [31:0] a);
    return a[31:8] == 24'h40_0000;
  endfunction

  function automatic bit is_ex(input logic [31:0] a);
    return in_win(a) && (a[7:0] == 8'h0C || a[7:0] == 8'h10);
  endfunction

  // Behavioural model: last grantee and length of its contended streak.
  int          last = -1;
  int          streak = 0;
  logic [31:0] e_rdata = '0;
  logic        e_rv0 = 1'b0, e_rv1 = 1'b0, e_err = 1'b0;

  always @(negedge clk) begin
    int          g;
    bit          r0, r1, other, we, by;
    logic [31:0] a, wd;
    r0 = bus.m0_req;
    r1 = bus.m1_req;
    if (reset) begin
      last = -1; streak = 0; e_rdata = '0; e_rv0 = 1'b0; e_rv1 = 1'b0; e_err = 1'b0;
    end
    chk32("rdata", bus.rdata, e_rdata);
    chk1("m0_rvalid", bus.m0_rvalid, e_rv0);
    chk1("m1_rvalid", bus.m1_rvalid, e_rv1);
    chk1("bus_err", bus.bus_err, e_err);

    if (reset)         g = -1;
    else if (r0 && r1) begin
      g = (last < 0) ? 0 : last;
      if (streak >= HM) g = 1 - g;
    end
    else if (r0)       g = 0;
    else if (r1)       g = 1;
    else               g = -1;

    we = (g == 1) ? bus.m1_we    : bus.m0_we;
    by = (g == 1) ? bus.m1_byte  : bus.m0_byte;
    a  = (g == 1) ? bus.m1_addr  : bus.m0_addr;
    wd = (g == 1) ? bus.m1_wdata : bus.m0_wdata;

    chk1("m0_gnt", bus.m0_gnt, g == 0);
    chk1("m1_gnt", bus.m1_gnt, g == 1);
    chk1("mem_write", bus.mem_write, g >= 0 && we && !in_win(a));
    chk1("mem_exwr", bus.mem_exwr, g >= 0 && we && is_ex(a));
    chk1("mem_read", bus.mem_read, g >= 0 && !we && !in_win(a) && !by);
    chk1("mem_byteread", bus.mem_byteread, g >= 0 && !we && !in_win(a) && by);
    if (g >= 0) begin
      chk32("mem_addr", bus.mem_addr, a);
      if (we) chk32("mem_wdata", bus.mem_wdata, wd);
    end

    if (!reset) begin
      other = (g == 0) ? r1 : (g == 1) ? r0 : 1'b0;
      if (g >= 0 && other) streak = (g == last) ? streak + 1 : 1;
      else                 streak = 0;
      last  = g;
      e_rv0 = (g == 0) && !we;
      e_rv1 = (g == 1) && !we;
      if (g >= 0 && !we) e_rdata = in_win(a) ? 32'h0 : bus.mem_rdata;
      if (g >= 0 && in_win(a) && !(we && is_ex(a))) e_err = 1'b1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.m0_req = 1'b0; bus.m0_we = 1'b0; bus.m0_byte = 1'b0; bus.m0_addr = '0; bus.m0_wdata = '0;
    bus.m1_req = 1'b0; bus.m1_we = 1'b0; bus.m1_byte = 1'b0; bus.m1_addr = '0; bus.m1_wdata = '0;
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 4))
      0:       return 32'h4000_000C;
      1:       return 32'h4000_0010;
      2:       return {24'h40_0000, 8'($urandom_range(0, 255))};
      default: return $urandom & 32'h0000_FFFF;
    endcase
  endfunction

  initial begin
    idle();
    bus.mem_rdata = '0;
    // Requests during reset must produce no strobes.
    bus.m0_req = 1'b1; bus.m0_addr = 32'h100;
    step();
    @(negedge clk);
    chk1("rst_gnt", bus.m0_gnt, 1'b0);
    chk1("rst_read", bus.mem_read, 1'b0);
    chk32("rst_rdata", bus.rdata, 32'h0);
    chk1("rst_err", bus.bus_err, 1'b0);

    // m0 word read from 0x10
    step();
    reset = 1'b0;
    bus.m0_addr = 32'h10; bus.mem_rdata = 32'h6361_6E20;
    @(negedge clk);
    chk1("r36_gnt", bus.m0_gnt, 1'b1);
    chk1("r36_read", bus.mem_read, 1'b1);
    step();
    idle(); bus.mem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    chk32("r36_rdata", bus.rdata, 32'h6361_6E20);
    chk1("r36_rvalid", bus.m0_rvalid, 1'b1);

    // Continuous contention from IDLE: four grants each, alternating
    step();
    bus.m0_req = 1'b1; bus.m0_addr = 32'h200;
    bus.m1_req = 1'b1; bus.m1_addr = 32'h300;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk1("r37_m0", bus.m0_gnt, ((i / 4) % 2) == 0);
      chk1("r37_m1", bus.m1_gnt, ((i / 4) % 2) == 1);
      step();
    end
    idle();

    // m1 byte read 0x201
    step();
    bus.m1_req = 1'b1; bus.m1_byte = 1'b1; bus.m1_addr = 32'h201; bus.mem_rdata = 32'h0000_00AB;
    @(negedge clk);
    chk1("r41_byteread", bus.mem_byteread, 1'b1);
    chk1("r41_read", bus.mem_read, 1'b0);
    step();
    idle();
    @(negedge clk);
    chk1("r41_rvalid", bus.m1_rvalid, 1'b1);
    chk32("r41_rdata", bus.rdata, 32'h0000_00AB);

    // m1 write to LED offset
    step();
    bus.m1_req = 1'b1; bus.m1_we = 1'b1; bus.m1_addr = 32'h4000_000C; bus.m1_wdata = 32'h55;
    @(negedge clk);
    chk1("r38_exwr", bus.mem_exwr, 1'b1);
    chk1("r38_write", bus.mem_write, 1'b0);
    chk32("r38_wdata", bus.mem_wdata, 32'h55);
    step();
    idle();
    @(negedge clk);
    chk1("r38_err", bus.bus_err, 1'b0);

    // m0 write to unmapped window offset
    step();
    bus.m0_req = 1'b1; bus.m0_we = 1'b1; bus.m0_addr = 32'h4000_0020;
    @(negedge clk);
    chk1("r39_write", bus.mem_write, 1'b0);
    chk1("r39_exwr", bus.mem_exwr, 1'b0);
    step();
    idle();
    @(negedge clk);
    chk1("r39_err", bus.bus_err, 1'b1);
    repeat (100) step();
    @(negedge clk);
    chk1("r39_err_held", bus.bus_err, 1'b1);

    // Reset right after a granted m1 read; state must come back as IDLE
    step();
    bus.m1_req = 1'b1; bus.m1_addr = 32'h300;
    step();
    reset = 1'b1;
    @(negedge clk);
    chk1("r40_rvalid", bus.m1_rvalid, 1'b0);
    chk1("r40_read", bus.mem_read, 1'b0);
    chk1("r40_gnt", bus.m1_gnt, 1'b0);
    step();
    reset = 1'b0;
    bus.m0_req = 1'b1; bus.m0_addr = 32'h400;
    @(negedge clk);
    chk1("r40_idle_m0", bus.m0_gnt, 1'b1);
    chk1("r40_rvalid_after", bus.m1_rvalid, 1'b0);
    step();
    idle();

    // Randomized traffic, occasional resets
    for (int c = 0; c < 800; c++) begin
      reset         = ($urandom_range(0, 60) == 0);
      bus.m0_req    = ($urandom_range(0, 3) != 0);
      bus.m1_req    = ($urandom_range(0, 3) != 0);
      bus.m0_we     = $urandom_range(0, 1) == 1;
      bus.m1_we     = $urandom_range(0, 1) == 1;
      bus.m0_byte   = $urandom_range(0, 1) == 1;
      bus.m1_byte   = $urandom_range(0, 1) == 1;
      bus.m0_addr   = rand_addr();
      bus.m1_addr   = rand_addr();
      bus.m0_wdata  = $urandom;
      bus.m1_wdata  = $urandom;
      bus.mem_rdata = $urandom;
      step();
    end
    reset = 1'b0;
    idle();
    step();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
